// File: rtl/wb_riscv_mtimer.sv
// RISC-V machine timer (64-bit mtime/mtimecmp) behind a 32-bit Wishbone B4 pipelined slave.
// Optional macro WB_RISCV_MTIMER_ERR_EN: unmapped accesses and writes to the frequency words answer with err_o.
module wb_riscv_mtimer #(
    parameter logic [63:0] CLK_FREQUENCY_HZ = 64'd100_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [4:0]  adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        irq_o
);

    localparam logic [2:0] WORD_MTIME_LO    = 3'd0;
    localparam logic [2:0] WORD_MTIME_HI    = 3'd1;
    localparam logic [2:0] WORD_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] WORD_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] WORD_FREQ_LO     = 3'd4;
    localparam logic [2:0] WORD_FREQ_HI     = 3'd5;

    logic [63:0] mtime_reg;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_reg;
    logic [63:0] mtimecmp_next;
    logic [31:0] dat_reg;
    logic [31:0] rd_data;
    logic        ack_reg;
    logic        ack_next;
    logic        accept;
    logic        wr_en;
    logic [2:0]  word_sel;
    logic [31:0] byte_mask;
    logic [31:0] mtime_lo_merged;
    logic [31:0] mtime_hi_merged;
    logic [31:0] mtimecmp_lo_merged;
    logic [31:0] mtimecmp_hi_merged;
    logic        unused_adr_bits;

    assign accept          = cyc_i & stb_i;
    assign wr_en           = accept & we_i;
    assign word_sel        = adr_i[4:2];
    assign unused_adr_bits = ^adr_i[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[8*gi +: 8] = {8{sel_i[gi]}};
        end
    endgenerate

    assign mtime_lo_merged    = (mtime_reg[31:0]     & ~byte_mask) | (dat_i & byte_mask);
    assign mtime_hi_merged    = (mtime_reg[63:32]    & ~byte_mask) | (dat_i & byte_mask);
    assign mtimecmp_lo_merged = (mtimecmp_reg[31:0]  & ~byte_mask) | (dat_i & byte_mask);
    assign mtimecmp_hi_merged = (mtimecmp_reg[63:32] & ~byte_mask) | (dat_i & byte_mask);

    // A write to either mtime half suppresses that cycle's increment for the full 64 bits.
    always_comb begin
        mtime_next = mtime_reg + 64'd1;
        if (wr_en && word_sel == WORD_MTIME_LO) begin
            mtime_next = {mtime_reg[63:32], mtime_lo_merged};
        end else if (wr_en && word_sel == WORD_MTIME_HI) begin
            mtime_next = {mtime_hi_merged, mtime_reg[31:0]};
        end
    end

    always_comb begin
        mtimecmp_next = mtimecmp_reg;
        if (wr_en && word_sel == WORD_MTIMECMP_LO) begin
            mtimecmp_next = {mtimecmp_reg[63:32], mtimecmp_lo_merged};
        end else if (wr_en && word_sel == WORD_MTIMECMP_HI) begin
            mtimecmp_next = {mtimecmp_hi_merged, mtimecmp_reg[31:0]};
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (word_sel)
            WORD_MTIME_LO:    rd_data = mtime_reg[31:0];
            WORD_MTIME_HI:    rd_data = mtime_reg[63:32];
            WORD_MTIMECMP_LO: rd_data = mtimecmp_reg[31:0];
            WORD_MTIMECMP_HI: rd_data = mtimecmp_reg[63:32];
            WORD_FREQ_LO:     rd_data = CLK_FREQUENCY_HZ[31:0];
            WORD_FREQ_HI:     rd_data = CLK_FREQUENCY_HZ[63:32];
            default:          rd_data = 32'd0;
        endcase
    end

`ifdef WB_RISCV_MTIMER_ERR_EN
    logic err_reg;
    logic err_next;
    logic bad_access;

    // Frequency words are read-only; offsets 0x18/0x1C are not decoded at all.
    assign bad_access = (word_sel[2:1] == 2'b11) ||
                        (we_i && (word_sel == WORD_FREQ_LO || word_sel == WORD_FREQ_HI));
    assign ack_next   = accept & ~bad_access;
    assign err_next   = accept & bad_access;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err_o = err_reg & cyc_i;
`else
    assign ack_next = accept;
    assign err_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_reg    <= 64'd0;
            mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
            ack_reg      <= 1'b0;
            dat_reg      <= 32'd0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            ack_reg      <= ack_next;
            if (accept && !we_i) begin
                dat_reg <= rd_data;
            end
        end
    end

    // Dropping cyc_i abandons any response still in flight.
    assign ack_o   = ack_reg & cyc_i;
    assign dat_o   = dat_reg;
    assign stall_o = 1'b0;
    assign irq_o   = (mtime_reg >= mtimecmp_reg);

endmodule

// File: tb/tb_wb_riscv_mtimer.sv
// Randomized self-checking bench for wb_riscv_mtimer; mtime is modelled as base value plus elapsed clock edges.
module tb_wb_riscv_mtimer;

    localparam logic [63:0] TB_FREQ = 64'hDEAD_BEEF_CAFE_AAAA;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  adr_i = 5'd0;
    logic [3:0]  sel_i = 4'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        stall_o;
    logic        err_o;
    logic        irq_o;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [63:0] edge_cnt = 64'd0;
    logic [63:0] mt_base = 64'd0;
    logic [63:0] mt_edge = 64'd0;
    logic [63:0] cmp_model = 64'hFFFF_FFFF_FFFF_FFFF;

    wb_riscv_mtimer #(.CLK_FREQUENCY_HZ(TB_FREQ)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .sel_i   (sel_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .stall_o (stall_o),
        .err_o   (err_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 64'd1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Counter value held after clock edge k.
    function automatic logic [63:0] mt_after(input logic [63:0] k);
        return mt_base + (k - mt_edge);
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Entered and left at 1 time unit after a rising edge; edge_cnt is then the accept edge.
    task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic got_ack, output logic got_err);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = wd;
        @(posedge clk_i);
        #1;
        stb_i = 1'b0; we_i = 1'b0;
        rd = dat_o; got_ack = ack_o; got_err = err_o;
        cyc_i = 1'b0;
        $display("wb %s adr=0x%02h sel=%b wdat=0x%08h rdat=0x%08h ack=%0b err=%0b",
                 we ? "WR" : "RD", adr, sel, wd, rd, got_ack, got_err);
    endtask

    task automatic check_resp(input string tag, input logic got_ack, input logic got_err,
                              input logic bad);
`ifdef WB_RISCV_MTIMER_ERR_EN
        check_val({tag, "_ack"}, {63'd0, got_ack}, {63'd0, ~bad});
        check_val({tag, "_err"}, {63'd0, got_err}, {63'd0, bad});
`else
        check_val({tag, "_ack"}, {63'd0, got_ack}, 64'd1);
        check_val({tag, "_err"}, {63'd0, got_err}, 64'd0);
`endif
    endtask

    task automatic bus_write(input logic [4:0] adr, input logic [3:0] sel, input logic [31:0] wd);
        logic [31:0] rd;
        logic a, r;
        logic [63:0] pre;
        wb_xfer(1'b1, adr, sel, wd, rd, a, r);
        check_resp("wr", a, r, adr[4:2] >= 3'd4);
        pre = mt_after(edge_cnt - 64'd1);
        case (adr[4:2])
            3'd0: begin mt_base = {pre[63:32], merge32(pre[31:0], wd, sel)}; mt_edge = edge_cnt; end
            3'd1: begin mt_base = {merge32(pre[63:32], wd, sel), pre[31:0]}; mt_edge = edge_cnt; end
            3'd2: cmp_model = {cmp_model[63:32], merge32(cmp_model[31:0], wd, sel)};
            3'd3: cmp_model = {merge32(cmp_model[63:32], wd, sel), cmp_model[31:0]};
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [4:0] adr, output logic [31:0] rd);
        logic a, r, bad;
        logic [63:0] pre;
        logic [31:0] exp;
        wb_xfer(1'b0, adr, 4'hF, 32'd0, rd, a, r);
        bad = (adr[4:3] == 2'b11);
        check_resp("rd", a, r, bad);
        pre = mt_after(edge_cnt - 64'd1);
        case (adr[4:2])
            3'd0: exp = pre[31:0];
            3'd1: exp = pre[63:32];
            3'd2: exp = cmp_model[31:0];
            3'd3: exp = cmp_model[63:32];
            3'd4: exp = TB_FREQ[31:0];
            3'd5: exp = TB_FREQ[63:32];
            default: exp = 32'd0;
        endcase
`ifdef WB_RISCV_MTIMER_ERR_EN
        if (!bad) check_val("rd_data", {32'd0, rd}, {32'd0, exp});
`else
        check_val("rd_data", {32'd0, rd}, {32'd0, exp});
`endif
    endtask

    task automatic check_irq(input string tag);
        check_val(tag, {63'd0, irq_o}, {63'd0, (mt_after(edge_cnt) >= cmp_model)});
    endtask

    task automatic write64(input logic [4:0] adr_lo, input logic [63:0] v);
        bus_write(adr_lo, 4'hF, v[31:0]);
        bus_write(adr_lo + 5'd4, 4'hF, v[63:32]);
    endtask

    initial begin
        logic [31:0] lo, hi;
        logic [63:0] first, second, mt, cmp;
        int delta;

        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_ack", {63'd0, ack_o}, 64'd0);
        check_val("rst_err", {63'd0, err_o}, 64'd0);
        check_val("rst_dat", {32'd0, dat_o}, 64'd0);
        check_val("rst_irq", {63'd0, irq_o}, 64'd0);
        check_val("stall", {63'd0, stall_o}, 64'd0);
        rst_ni = 1'b1;
        mt_base = 64'd0; mt_edge = edge_cnt; cmp_model = 64'hFFFF_FFFF_FFFF_FFFF;

        bus_read(5'h10, lo);
        bus_read(5'h14, hi);
        check_val("freq", {hi, lo}, TB_FREQ);
        check_irq("irq_after_rst");

        for (int i = 0; i < 100; i++) begin
            bus_read(5'h00, lo);
            bus_read(5'h04, hi);
            first = {hi, lo};
            idle($urandom_range(0, 600));
            bus_read(5'h00, lo);
            bus_read(5'h04, hi);
            second = {hi, lo};
            check_val("mono", {63'd0, second > first}, 64'd1);
        end

        bus_write(5'h00, 4'hF, 32'd0);
        bus_write(5'h04, 4'hF, 32'd0);
        bus_read(5'h00, lo);
        bus_read(5'h04, hi);
        check_val("mt_small", {63'd0, {hi, lo} <= 64'd2}, 64'd1);
        cmp = {$urandom, $urandom};
        write64(5'h08, cmp);
        bus_read(5'h08, lo);
        bus_read(5'h0C, hi);
        check_val("cmp_rdback", {hi, lo}, cmp);

        write64(5'h00, 64'd0);
        write64(5'h08, 64'h0000_0000_0000_0FFF);
        check_irq("irq_low");
        for (int i = 0; i < 6000 && !irq_o; i++) idle(1);
        check_val("irq_rise", {63'd0, irq_o}, 64'd1);
        check_val("irq_rise_time", mt_after(edge_cnt), cmp_model);
        bus_write(5'h08, 4'hF, 32'h000F_FFFF);
        check_irq("irq_clear");
        check_val("irq_clear_lvl", {63'd0, irq_o}, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            mt = {$urandom, $urandom};
            delta = int'($urandom_range(0, 20)) - 10;
            cmp = (i % 4 == 0) ? {$urandom, $urandom} : mt + 64'(signed'(delta));
            write64(5'h08, cmp);
            write64(5'h00, mt);
            idle($urandom_range(0, 3));
            check_irq("irq_rand");
        end

        write64(5'h08, 64'h1122_3344_5566_7788);
        bus_write(5'h08, 4'b0010, 32'h0000_AB00);
        bus_read(5'h08, lo);
        bus_read(5'h0C, hi);
        check_val("byte_wr", {hi, lo}, 64'h1122_3344_5566_AB88);
        bus_write(5'h10, 4'hF, 32'h1234_5678);
        bus_write(5'h1C, 4'hF, 32'h1234_5678);
        bus_read(5'h10, lo);
        bus_read(5'h18, lo);
        bus_read(5'h0C, hi);

        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 5'h00; sel_i = 4'hF;
        @(posedge clk_i);
        #1;
        stb_i = 1'b0; cyc_i = 1'b0;
        #1;
        check_val("cyc_drop_ack", {63'd0, ack_o}, 64'd0);
        idle(1);

        write64(5'h08, 64'd5);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 5'h00;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_val("rst_mid_ack", {63'd0, ack_o}, 64'd0);
        check_val("rst_mid_irq", {63'd0, irq_o}, 64'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mt_base = 64'd0; mt_edge = edge_cnt; cmp_model = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_read(5'h00, lo);
        bus_read(5'h0C, hi);
        check_irq("irq_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
